axi_slave_wr_mem: RTL
=====================

// Module: axi_slave_wr_mem
// PURPOSE
//  AXI3-style write-path slave behind axi_if. Consumes AW and W bursts and writes
//  strobed data into a local 32-bit word memory. Returns one B response per burst.
//  Drives next_addrwr so the bench can track address generation beat by beat.
// PARAMETERS
//  DEPTH   1024  memory depth in 32-bit words; byte address range is 0..DEPTH*4-1
//  AW      32    address width
// PORTS
//  clk         in   1   clock, rising edge
//  resetn      in   1   asynchronous active-low reset
//  awvalid     in   1   write address valid
//  awready     out  1   write address accepted
//  awid        in   4   transaction ID
//  awlen       in   4   beats-1 (1..16 beats)
//  awsize      in   3   bytes/beat = 1<<awsize; only 0..2 are legal
//  awaddr      in   32  start byte address
//  awburst     in   2   00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  wvalid      in   1   write data valid
//  wready      out  1   write data accepted
//  wid         in   4   write data ID
//  wdata       in   32  write data
//  wstrb       in   4   byte-lane enables
//  wlast       in   1   last beat marker
//  bvalid      out  1   response valid
//  bready      in   1   response accepted by master
//  bid         out  4   awid latched for this burst
//  bresp       out  2   00 OKAY, 10 SLVERR
//  next_addrwr out  32  byte address of the next beat
//  dbg_addr    in   32  debug read byte address (word-aligned)
//  dbg_rdata   out  32  combinational memory read at dbg_addr[..2]
// BEHAVIOUR
//  Reset: state IDLE; awready, wready, bvalid, bid, bresp, next_addrwr and error flag
//   all clear to 0. Memory contents are not reset.
//  FSM IDLE -> DATA -> RESP -> IDLE. All outputs are registered.
//   - IDLE: awready=1 from the first cycle after reset release. On awvalid&awready:
//     latch id/len/size/burst; next_addrwr<=awaddr; beat cnt<=0; err<=0;
//     awready<=0, wready<=1. Go to DATA.
//   - DATA: on each wvalid&wready beat:
//     - write the wstrb lanes of wdata to mem[next_addrwr>>2];
//     - advance next_addrwr; cnt++.
//     - On the beat where cnt==len: wready<=0, bvalid<=1, bid<=id, bresp<=err?10:00.
//       Go to RESP.
//     - wvalid without wready is not consumed.
//   - RESP: hold bvalid/bid/bresp until bready. Then bvalid<=0, awready<=1, go to IDLE.
//     bvalid&bready costs 1 cycle; no overlap of AW with RESP.
//  Address generation (N=1<<size), applied after every beat:
//   - FIXED: next_addrwr is unchanged.
//   - INCR: next_addrwr+N, modulo 2^32.
//   - WRAP: boundary B = N*(len+1), lo = addr & ~(B-1); next = addr+N, and if next == lo+B
//     then next = lo. Legal WRAP len is 1, 3, 7 or 15 and awaddr must be N-aligned;
//     otherwise err=1.
//  Error (err sticky per burst; bresp=SLVERR):
//   - awburst==11, or awsize>2 => all beats discarded (no writes).
//   - Beat address >= DEPTH*4 => that beat is discarded.
//   - wlast != (cnt==len) on any beat; the burst still ends after len+1 beats.
//  Simultaneous events:
//   - awvalid during DATA/RESP stalls (awready=0).
//   - bready already high when bvalid rises => handshake in that cycle.
//  Reset mid-burst: returns to IDLE immediately; partial writes are kept; no B is issued.
// CONFIGURATION
//  AXI_WID_CHECK_EN defined:
//   - Each beat with wid != latched awid is discarded and sets err (bresp=SLVERR).
//   - Beat counting continues normally.
//  AXI_WID_CHECK_EN undefined: wid is ignored entirely.
// TESTING
//  1. Reset: assert resetn=0 mid-DATA -> next cycle awready=wready=bvalid=0.
//     After release, awready=1 one cycle later.
//  2. INCR: awaddr=0x10, len=3, size=2, id=5; wdata 0xA0..0xA3, wstrb=F ->
//     mem words 4..7 = A0..A3; bid=5, bresp=00.
//  3. WRAP: awaddr=0x38, len=3, size=2 -> beat addresses 0x38, 0x3C, 0x30, 0x34; bresp=00.
//  4. FIXED + strobe: awaddr=0x8, len=1, wdata 0x11223344 (F) then 0xAABBCCDD (wstrb=0011)
//     -> mem[2]=0x1122CCDD.
//  5. Errors: awburst=11 -> no writes, bresp=10. wlast early on beat 0 of len=1 -> bresp=10.
//     addr=DEPTH*4 -> bresp=10.
//  6. WID (macro on): awid=3, beat 1 wid=4 -> beat 1 not written, bresp=10.
//     Same stimulus with the macro off -> bresp=00.

Source files
------------

// File: rtl/axi_slave_wr_mem.sv
// axi_slave_wr_mem: AXI3-style write-path slave backed by a 32-bit word memory.
// Accepts one AW burst at a time, writes its strobed beats, then returns one B.
// Optional feature macro: AXI_WID_CHECK_EN. When it is defined, each beat whose
// wid differs from the latched awid is dropped and flagged as SLVERR. When it is
// undefined, wid is ignored.
module axi_slave_wr_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          awvalid,
  output logic          awready,
  input  logic [3:0]    awid,
  input  logic [3:0]    awlen,
  input  logic [2:0]    awsize,
  input  logic [AW-1:0] awaddr,
  input  logic [1:0]    awburst,
  input  logic          wvalid,
  output logic          wready,
  input  logic [3:0]    wid,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic          wlast,
  output logic          bvalid,
  input  logic          bready,
  output logic [3:0]    bid,
  output logic [1:0]    bresp,
  output logic [AW-1:0] next_addrwr,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_rdata
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [AW-1:0] MEM_BYTES = AW'(DEPTH * 4);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t     state;
  logic [3:0] id_q;
  logic [3:0] len_q;
  logic [2:0] size_q;
  logic [1:0] burst_q;
  logic [3:0] cnt;
  logic       err;
  logic       drop_all;

  logic [31:0] mem [DEPTH];

  // AW-time checks
  logic          aw_drop;
  logic          wrap_bad;
  logic          aw_bad;
  logic [AW-1:0] aw_mask;

  // per-beat decode
  logic          beat;
  logic          beat_last;
  logic          in_range;
  logic          wid_ok;
  logic          beat_wr;
  logic          beat_err;
  logic [IW-1:0] widx;

  // address generation
  logic [AW-1:0] step;
  logic [AW-1:0] bound;
  logic [AW-1:0] lo;
  logic [AW-1:0] inc;
  logic [AW-1:0] addr_nx;

  logic unused_in;

`ifdef AXI_WID_CHECK_EN
  assign wid_ok    = (wid == id_q);
  assign unused_in = ^{dbg_addr[AW-1:IW+2], dbg_addr[1:0]};
`else
  assign wid_ok    = 1'b1;
  assign unused_in = ^{wid, dbg_addr[AW-1:IW+2], dbg_addr[1:0]};
`endif

  // Classify the incoming AW request. A reserved burst type or an oversized
  // beat poisons the whole burst. An illegal WRAP only raises the error flag;
  // its beats are still written.
  always_comb begin
    aw_drop  = (awburst == BURST_RSVD) || (awsize > 3'd2);
    aw_mask  = (AW'(1) << awsize) - AW'(1);
    wrap_bad = (awburst == BURST_WRAP) &&
               (!(awlen inside {4'd1, 4'd3, 4'd7, 4'd15}) || ((awaddr & aw_mask) != '0));
    aw_bad   = aw_drop || wrap_bad;
  end

  // Address of the beat after the current one, from the latched burst shape.
  always_comb begin
    step  = AW'(1) << size_q;
    bound = step * (AW'(len_q) + AW'(1));
    lo    = next_addrwr & ~(bound - AW'(1));
    inc   = next_addrwr + step;
    case (burst_q)
      BURST_FIXED: addr_nx = next_addrwr;
      BURST_WRAP:  addr_nx = (inc == lo + bound) ? lo : inc;
      default:     addr_nx = inc;
    endcase
  end

  // Qualify the current beat. An out-of-range or wrong-ID beat is dropped.
  // A wlast mismatch only flags the error; the beat count alone ends the burst.
  always_comb begin
    beat      = (state == DATA) && wvalid && wready;
    beat_last = (cnt == len_q);
    in_range  = (next_addrwr < MEM_BYTES);
    beat_wr   = beat && !drop_all && in_range && wid_ok;
    beat_err  = !in_range || !wid_ok || (wlast != beat_last);
    widx      = next_addrwr[IW+1:2];
  end

  // Byte-lane write into the word memory. The memory is not reset.
  always_ff @(posedge clk) begin
    if (beat_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign dbg_rdata = mem[dbg_addr[IW+1:2]];

  // Burst FSM. Every handshake output is registered here.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      awready     <= 1'b0;
      wready      <= 1'b0;
      bvalid      <= 1'b0;
      bid         <= '0;
      bresp       <= RESP_OKAY;
      next_addrwr <= '0;
      err         <= 1'b0;
      drop_all    <= 1'b0;
      id_q        <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (awvalid && awready) begin
            id_q        <= awid;
            len_q       <= awlen;
            size_q      <= awsize;
            burst_q     <= awburst;
            next_addrwr <= awaddr;
            cnt         <= '0;
            // The error flag starts each burst from the AW-time verdict.
            err         <= aw_bad;
            drop_all    <= aw_drop;
            awready     <= 1'b0;
            wready      <= 1'b1;
            state       <= DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        DATA: begin
          if (beat) begin
            next_addrwr <= addr_nx;
            cnt         <= cnt + 4'd1;
            if (beat_err) err <= 1'b1;
            if (beat_last) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bid    <= id_q;
              bresp  <= (err || beat_err) ? RESP_SLVERR : RESP_OKAY;
              state  <= RESP;
            end
          end
        end
        RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
